// File: rtl/cache_arbiter.sv
// cache_arbiter: shares the single physical-memory line port between the
// I-cache and D-cache controllers, one whole-line transaction at a time.
// All memory-side commands are registered; responses are steered back to
// whichever cache holds the grant.
//
// Optional build macro: ARB_ROUND_ROBIN_EN
//   defined   - a simultaneous I/D request is granted opposite to the
//               previous grant (last_grant register is built)
//   undefined - a simultaneous I/D request always goes to the D-cache
//
// state  | meaning
// IDLE   | no transaction; requests evaluated here
// I_BUSY | I-cache line read outstanding on pmem
// D_BUSY | D-cache line read or write-back outstanding on pmem
// DONE   | dead cycle so the served cache can drop its request

module cache_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2,
    DONE   = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic                pmem_read_q, pmem_read_d;
  logic                pmem_write_q, pmem_write_d;
  logic [ADDR_W-1:0]   pmem_address_q, pmem_address_d;
  logic [LINE_W-1:0]   pmem_wdata_q, pmem_wdata_d;
  logic                i_req;
  logic                d_req;
  logic                grant_d_side;

`ifdef ARB_ROUND_ROBIN_EN
  // 1 = D-cache held the most recent grant, 0 = I-cache
  logic                last_grant_q, last_grant_d;
`endif

  // Decide which cache would win if the FSM grants this cycle
  always_comb begin
    i_req = i_read;
    d_req = d_read | d_write;
`ifdef ARB_ROUND_ROBIN_EN
    grant_d_side = d_req & (~i_req | ~last_grant_q);
`else
    grant_d_side = d_req;
`endif
  end

  // Next-state, registered-command and combinational-response logic
  always_comb begin
    state_d        = state_q;
    pmem_read_d    = pmem_read_q;
    pmem_write_d   = pmem_write_q;
    pmem_address_d = pmem_address_q;
    pmem_wdata_d   = pmem_wdata_q;
    i_resp         = 1'b0;
    d_resp         = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    last_grant_d   = last_grant_q;
`endif
    case (state_q)
      IDLE: begin
        if (grant_d_side) begin
          state_d        = D_BUSY;
          pmem_address_d = d_addr;
          // a write-back wins over a read asserted in the same cycle
          if (d_write) begin
            pmem_write_d = 1'b1;
            pmem_wdata_d = d_wdata;
          end else begin
            pmem_read_d  = 1'b1;
          end
`ifdef ARB_ROUND_ROBIN_EN
          last_grant_d = 1'b1;
`endif
        end else if (i_req) begin
          state_d        = I_BUSY;
          pmem_read_d    = 1'b1;
          pmem_address_d = i_addr;
`ifdef ARB_ROUND_ROBIN_EN
          last_grant_d   = 1'b0;
`endif
        end
      end
      I_BUSY: begin
        if (pmem_resp) begin
          i_resp       = 1'b1;
          pmem_read_d  = 1'b0;
          pmem_write_d = 1'b0;
          state_d      = DONE;
        end
      end
      D_BUSY: begin
        if (pmem_resp) begin
          d_resp       = 1'b1;
          pmem_read_d  = 1'b0;
          pmem_write_d = 1'b0;
          state_d      = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and memory-command registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      pmem_read_q    <= 1'b0;
      pmem_write_q   <= 1'b0;
      pmem_address_q <= '0;
      pmem_wdata_q   <= '0;
    end else begin
      state_q        <= state_d;
      pmem_read_q    <= pmem_read_d;
      pmem_write_q   <= pmem_write_d;
      pmem_address_q <= pmem_address_d;
      pmem_wdata_q   <= pmem_wdata_d;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  // Remember who was granted last; resets to the I-cache
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant_q <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`endif

  assign pmem_read    = pmem_read_q;
  assign pmem_write   = pmem_write_q;
  assign pmem_address = pmem_address_q;
  assign pmem_wdata   = pmem_wdata_q;

  // read data is broadcast; only the matching resp qualifies it
  assign i_rdata = pmem_rdata;
  assign d_rdata = pmem_rdata;

endmodule

// File: tb/tb_cache_arbiter.sv
// Bench for cache_arbiter: directed scenarios followed by random rounds,
// predicted by a transaction-level model of pending requests and grants.
module tb_cache_arbiter;

  localparam int AW = 32;
  localparam int LW = 256;

  logic          clk;
  logic          rst;
  logic          i_read;
  logic [AW-1:0] i_addr;
  logic [LW-1:0] i_rdata;
  logic          i_resp;
  logic          d_read;
  logic          d_write;
  logic [AW-1:0] d_addr;
  logic [LW-1:0] d_wdata;
  logic [LW-1:0] d_rdata;
  logic          d_resp;
  logic          pmem_read;
  logic          pmem_write;
  logic [AW-1:0] pmem_address;
  logic [LW-1:0] pmem_wdata;
  logic [LW-1:0] pmem_rdata;
  logic          pmem_resp;

  int vectors = 0;
  int miscompares = 0;

  // reference model: outstanding requests and who was granted last
  bit            i_pend, d_pend, d_pend_wr, last_d;
  logic [AW-1:0] i_pend_addr, d_pend_addr;
  logic [LW-1:0] d_pend_wdata;

  cache_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] v;
    for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Busy phase through DONE and back to IDLE; returns inside the IDLE cycle
  task automatic serve(input bit gnt_d, input bit e_rd, input bit e_wr,
                       input logic [AW-1:0] e_addr, input logic [LW-1:0] e_wd,
                       input int dly, input logic [LW-1:0] rd);
    for (int k = 0; k < dly; k++) begin
      if (gnt_d) begin
        d_addr  = $urandom;
        d_wdata = rand_line();
      end else begin
        i_addr = $urandom;
      end
      pmem_rdata = rand_line();
      #1;
      chk("busy_read", pmem_read, e_rd);
      chk("busy_write", pmem_write, e_wr);
      chk("busy_addr", pmem_address, e_addr);
      if (e_wr) chk("busy_wdata", pmem_wdata, e_wd);
      chk("busy_i_resp", i_resp, 1'b0);
      chk("busy_d_resp", d_resp, 1'b0);
      tick();
    end
    pmem_rdata = rd;
    pmem_resp  = 1'b1;
    #1;
    chk("resp_owner", gnt_d ? d_resp : i_resp, 1'b1);
    chk("resp_other", gnt_d ? i_resp : d_resp, 1'b0);
    chk("rdata_owner", gnt_d ? d_rdata : i_rdata, rd);
    chk("rdata_other", gnt_d ? i_rdata : d_rdata, rd);
    tick();
    // DONE: owner drops its request; pmem_resp kept high must be ignored
    if (gnt_d) begin
      d_read = 1'b0; d_write = 1'b0; d_pend = 1'b0;
    end else begin
      i_read = 1'b0; i_pend = 1'b0;
    end
    pmem_rdata = rand_line();
    #1;
    chk("done_read", pmem_read, 1'b0);
    chk("done_write", pmem_write, 1'b0);
    chk("done_i_resp", i_resp, 1'b0);
    chk("done_d_resp", d_resp, 1'b0);
    tick();
    #1;
    chk("idle_read", pmem_read, 1'b0);
    chk("idle_write", pmem_write, 1'b0);
    chk("idle_i_resp", i_resp, 1'b0);
    chk("idle_d_resp", d_resp, 1'b0);
    pmem_resp = 1'b0;
  endtask

  // One arbitration round, entered and left inside an IDLE cycle
  task automatic round(input bit req_i, input bit req_d, input bit d_rd, input bit d_wr,
                       input logic [AW-1:0] ia, input logic [AW-1:0] da,
                       input logic [LW-1:0] dw, input int dly, input logic [LW-1:0] rd);
    bit            gnt_d, e_rd, e_wr;
    logic [AW-1:0] e_addr;
    if (req_i && !i_pend) begin
      i_pend = 1'b1; i_pend_addr = ia;
      i_read = 1'b1; i_addr = ia;
    end
    if (req_d && !d_pend) begin
      d_pend = 1'b1; d_pend_wr = d_wr; d_pend_addr = da; d_pend_wdata = dw;
      d_read = d_rd | ~d_wr; d_write = d_wr; d_addr = da; d_wdata = dw;
    end
    if (!i_pend && !d_pend) begin
      tick();
      chk("noreq_read", pmem_read, 1'b0);
      chk("noreq_write", pmem_write, 1'b0);
    end else begin
      if (i_pend && d_pend) begin
`ifdef ARB_ROUND_ROBIN_EN
        gnt_d = !last_d;
`else
        gnt_d = 1'b1;
`endif
      end else begin
        gnt_d = d_pend;
      end
      last_d = gnt_d;
      e_wr   = gnt_d && d_pend_wr;
      e_rd   = !e_wr;
      e_addr = gnt_d ? d_pend_addr : i_pend_addr;
      tick();
      chk("grant_read", pmem_read, e_rd);
      chk("grant_write", pmem_write, e_wr);
      chk("grant_addr", pmem_address, e_addr);
      if (e_wr) chk("grant_wdata", pmem_wdata, d_pend_wdata);
      serve(gnt_d, e_rd, e_wr, e_addr, d_pend_wdata, dly, rd);
    end
  endtask

  initial begin
    bit rw;
    rst = 1'b0; i_read = 1'b1; i_addr = 32'h0000_2000;
    d_read = 1'b0; d_write = 1'b0; d_addr = '0; d_wdata = '0;
    pmem_rdata = rand_line(); pmem_resp = 1'b1;
    i_pend = 1'b0; d_pend = 1'b0; d_pend_wr = 1'b0; last_d = 1'b0;
    i_pend_addr = '0; d_pend_addr = '0; d_pend_wdata = '0;

    // reset held with an I request and a spurious pmem_resp
    repeat (3) @(posedge clk);
    #1;
    chk("rst_read", pmem_read, 1'b0);
    chk("rst_write", pmem_write, 1'b0);
    chk("rst_addr", pmem_address, '0);
    chk("rst_wdata", pmem_wdata, '0);
    chk("rst_i_resp", i_resp, 1'b0);
    chk("rst_d_resp", d_resp, 1'b0);
    pmem_resp = 1'b0;
    rst = 1'b1;
    i_pend = 1'b1; i_pend_addr = 32'h0000_2000;
    round(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, 2, rand_line());

    // I-cache line read
    round(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_1040, '0, '0, 5, {32{8'hA5}});

    // three back-to-back ties, then drain whatever is left pending
    repeat (3) round(1'b1, 1'b1, 1'b1, 1'b0, $urandom, $urandom, rand_line(), 1, rand_line());
    repeat (2) round(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, 1, rand_line());

    // D-cache write-back
    round(1'b0, 1'b1, 1'b0, 1'b1, '0, 32'h0000_8000, {8{32'h1234_5678}}, 3, rand_line());

    // random traffic, including read+write asserted together
    repeat (60) begin
      rw = 1'($urandom_range(0, 1));
      round(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            rw ? 1'($urandom_range(0, 1)) : 1'b1, rw,
            $urandom, $urandom, rand_line(), $urandom_range(0, 4), rand_line());
    end
    repeat (2) round(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, 1, rand_line());

    // reset in the cycle before pmem_resp of a D read
    d_read = 1'b1; d_addr = 32'h0000_4400;
    tick();
    chk("abort_grant", pmem_read, 1'b1);
    tick();
    rst = 1'b0;
    #1;
    chk("abort_read", pmem_read, 1'b0);
    chk("abort_addr", pmem_address, '0);
    chk("abort_d_resp", d_resp, 1'b0);
    tick();
    pmem_resp = 1'b1;
    #1;
    chk("abort_resp_d", d_resp, 1'b0);
    chk("abort_resp_i", i_resp, 1'b0);
    d_read = 1'b0; pmem_resp = 1'b0; rst = 1'b1;
    i_pend = 1'b0; d_pend = 1'b0; last_d = 1'b0;
    tick();
    chk("abort_idle_read", pmem_read, 1'b0);
    round(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0C00, '0, '0, 1, rand_line());
    round(1'b1, 1'b1, 1'b1, 1'b0, $urandom, $urandom, rand_line(), 0, rand_line());
    repeat (2) round(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, 0, rand_line());

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
